// File: rtl/decode_if.sv
// Decode-stage bus: fetch handshake, register-file write-back from execution,
// and the registered issue bundle that feeds execution.
interface decode_if;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        wb_we;
    logic [3:0]  wb_rdest;
    logic [15:0] wb_data;
    logic [15:0] rd_data;
    logic [15:0] s0;
    logic [1:0]  aluctr;
    logic [15:0] im16;
    logic        s2ctr;
    logic        we;
    logic [3:0]  rdest_r;
    logic        halted;

    modport master (
        output inst, inst_valid, wb_we, wb_rdest, wb_data,
        input  inst_ready, rd_data, s0, aluctr, im16, s2ctr, we, rdest_r, halted
    );
    modport slave (
        input  inst, inst_valid, wb_we, wb_rdest, wb_data,
        output inst_ready, rd_data, s0, aluctr, im16, s2ctr, we, rdest_r, halted
    );
endinterface

// File: rtl/decode.sv
// Instruction decode / register-read stage: 16x16 register file with write-through
// bypass, two-word LDI, one-cycle RAW stall against the issued bundle, and HALT.
module decode (
    input  logic     clk,
    input  logic     rst,
    decode_if.slave  bus
);
    typedef enum logic [1:0] {S_RUN, S_IMM, S_HALT} state_t;

    typedef struct packed {
        logic [15:0] rd_data;
        logic [15:0] s0;
        logic [1:0]  aluctr;
        logic [15:0] im16;
        logic        s2ctr;
        logic        we;
        logic [3:0]  rdest;
    } issue_t;

    state_t      r_state, w_state_nxt;
    issue_t      r_iss, w_iss_nxt;
    logic [3:0]  r_rd_lat, w_rd_lat_nxt;
    logic        r_halted;
    logic [15:0] r_rf [16];

    logic [3:0]  w_op, w_rd, w_rs;
    logic        w_is_alu, w_stall, w_acc;
    logic [1:0]  w_alu;
    logic [15:0] w_rd_val, w_rs_val;

    assign w_op = bus.inst[15:12];
    assign w_rd = bus.inst[11:8];
    assign w_rs = bus.inst[7:4];

    always_comb begin
        w_is_alu = 1'b1;
        w_alu    = 2'b00;
        case (w_op)
            4'h1:    w_alu = 2'b00;
            4'h2:    w_alu = 2'b01;
            4'h3:    w_alu = 2'b10;
            4'h4:    w_alu = 2'b11;
            default: w_is_alu = 1'b0;
        endcase
    end

    // Only a distance-1 dependency needs a bubble; by the next cycle the
    // result arrives on wb_* and the read bypass supplies it.
    assign w_stall = (r_state == S_RUN) && bus.inst_valid && w_is_alu && r_iss.we &&
                     ((w_rd == r_iss.rdest) || (w_rs == r_iss.rdest));

    assign bus.inst_ready = !rst && (r_state != S_HALT) && !w_stall;
    assign w_acc          = bus.inst_valid && bus.inst_ready;

    assign w_rd_val = (bus.wb_we && bus.wb_rdest == w_rd) ? bus.wb_data : r_rf[w_rd];
    assign w_rs_val = (bus.wb_we && bus.wb_rdest == w_rs) ? bus.wb_data : r_rf[w_rs];

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_lat_nxt = r_rd_lat;
        w_iss_nxt    = '0;
        case (r_state)
            S_RUN: begin
                if (w_acc) begin
                    if (w_is_alu) begin
                        w_iss_nxt.we      = 1'b1;
                        w_iss_nxt.aluctr  = w_alu;
                        w_iss_nxt.rdest   = w_rd;
                        w_iss_nxt.rd_data = w_rd_val;
                        w_iss_nxt.s0      = w_rs_val;
                    end else if (w_op == 4'h8) begin
                        w_rd_lat_nxt = w_rd;
                        w_state_nxt  = S_IMM;
                    end else if (w_op == 4'hF) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_IMM: begin
                if (w_acc) begin
                    w_iss_nxt.we    = 1'b1;
                    w_iss_nxt.s2ctr = 1'b1;
                    w_iss_nxt.im16  = bus.inst;
                    w_iss_nxt.rdest = r_rd_lat;
                    w_state_nxt     = S_RUN;
                end
            end
            S_HALT: ;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_iss    <= '0;
            r_rd_lat <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_iss    <= w_iss_nxt;
            r_rd_lat <= w_rd_lat_nxt;
            r_halted <= (w_state_nxt == S_HALT);
        end
    end

    // Write-back lands in every state, including stall and HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else if (bus.wb_we) begin
            r_rf[bus.wb_rdest] <= bus.wb_data;
        end
    end

    assign bus.rd_data = r_iss.rd_data;
    assign bus.s0      = r_iss.s0;
    assign bus.aluctr  = r_iss.aluctr;
    assign bus.im16    = r_iss.im16;
    assign bus.s2ctr   = r_iss.s2ctr;
    assign bus.we      = r_iss.we;
    assign bus.rdest_r = r_iss.rdest;
    assign bus.halted  = r_halted;
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: a cycle-level reference model checks every output
// each cycle, and literal expectations pin key points of the sequence.
module tb_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_if bus ();
    decode dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_mode = 0;   // 0 run, 1 waiting for immediate, 2 halted
    logic [15:0] m_rf [16];
    logic [3:0]  m_lat = '0;
    logic        m_halt = 1'b0;
    logic [15:0] e_rd = '0, e_s0 = '0, e_im = '0;
    logic [1:0]  e_alu = '0;
    logic        e_s2 = 1'b0, e_we = 1'b0;
    logic [3:0]  e_rdest = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic f_ready();
        logic [3:0] op, rd, rs;
        op = bus.inst[15:12];
        rd = bus.inst[11:8];
        rs = bus.inst[7:4];
        if (rst || m_mode == 2) return 1'b0;
        if (m_mode == 0 && bus.inst_valid && op >= 4'h1 && op <= 4'h4 && e_we &&
            (rd == e_rdest || rs == e_rdest)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic       acc;
        logic [3:0] op, rd, rs;
        acc = bus.inst_valid && f_ready();
        op  = bus.inst[15:12];
        rd  = bus.inst[11:8];
        rs  = bus.inst[7:4];
        {e_rd, e_s0, e_alu, e_im, e_s2, e_we, e_rdest} = '0;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_rf[i] = '0;
            m_mode = 0;
            m_lat  = '0;
            m_halt = 1'b0;
            return;
        end
        // applying the write first makes same-cycle reads see the new value
        if (bus.wb_we) m_rf[bus.wb_rdest] = bus.wb_data;
        if (!acc) return;
        if (m_mode == 1) begin
            e_we = 1'b1; e_s2 = 1'b1; e_im = bus.inst; e_rdest = m_lat;
            m_mode = 0;
        end else if (op >= 4'h1 && op <= 4'h4) begin
            e_we = 1'b1; e_alu = 2'(op - 4'd1); e_rdest = rd;
            e_rd = m_rf[rd]; e_s0 = m_rf[rs];
        end else if (op == 4'h8) begin
            m_lat = rd; m_mode = 1;
        end else if (op == 4'hF) begin
            m_mode = 2; m_halt = 1'b1;
        end
    endtask

    // Apply one cycle of inputs, check ready, advance model, compare all outputs.
    task automatic step(input logic r, input logic v, input logic [15:0] w,
                        input logic wwe, input logic [3:0] wa, input logic [15:0] wd);
        rst = r;
        bus.inst = w; bus.inst_valid = v;
        bus.wb_we = wwe; bus.wb_rdest = wa; bus.wb_data = wd;
        #1 chk("inst_ready", 16'(bus.inst_ready), 16'(f_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("rd_data", bus.rd_data, e_rd);
        chk("s0", bus.s0, e_s0);
        chk("aluctr", 16'(bus.aluctr), 16'(e_alu));
        chk("im16", bus.im16, e_im);
        chk("s2ctr", 16'(bus.s2ctr), 16'(e_s2));
        chk("we", 16'(bus.we), 16'(e_we));
        chk("rdest_r", 16'(bus.rdest_r), 16'(e_rdest));
        chk("halted", 16'(bus.halted), 16'(m_halt));
    endtask

    task automatic ins(input logic [15:0] w);
        step(1'b0, 1'b1, w, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic wb(input logic [3:0] a, input logic [15:0] d);
        step(1'b0, 1'b0, 16'h0, 1'b1, a, d);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        bus.inst = '0; bus.inst_valid = 1'b0;
        bus.wb_we = 1'b0; bus.wb_rdest = '0; bus.wb_data = '0;
        @(negedge clk);
        step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
        wb(4'h1, 16'h0011);
        wb(4'h2, 16'h0022);

        // reset with a pending word: not accepted, outputs stay zero, RF cleared
        step(1'b1, 1'b1, 16'h1120, 1'b0, 4'h0, 16'h0);
        chk("rst_ready0", 16'(bus.inst_ready), 16'h0);
        step(1'b1, 1'b1, 16'h1120, 1'b0, 4'h0, 16'h0);
        chk("rst_ready1", 16'(bus.inst_ready), 16'h0);
        chk("rst_we", 16'(bus.we), 16'h0);
        ins(16'h1120);
        chk("rst_rf_rd", bus.rd_data, 16'h0000);
        chk("rst_rf_rs", bus.s0, 16'h0000);
        chk("add_rdest", 16'(bus.rdest_r), 16'h1);

        wb(4'h1, 16'h0011);
        wb(4'h2, 16'h0022);
        ins(16'h1120);
        chk("add_rd", bus.rd_data, 16'h0011);
        chk("add_rs", bus.s0, 16'h0022);

        // LDI back-to-back
        ins(16'h8100);
        chk("ldi1_we", 16'(bus.we), 16'h0);
        chk("ldi1_ready", 16'(bus.inst_ready), 16'h1);
        ins(16'h1234);
        chk("ldi2_im16", bus.im16, 16'h1234);
        chk("ldi2_s2ctr", 16'(bus.s2ctr), 16'h1);
        chk("ldi2_rdest", 16'(bus.rdest_r), 16'h1);

        // same-cycle write/read bypass
        ins(16'h0000);
        step(1'b0, 1'b1, 16'h1120, 1'b1, 4'h2, 16'h00AA);
        chk("byp_s0", bus.s0, 16'h00AA);
        chk("byp_rd", bus.rd_data, 16'h0011);

        // RAW stall: SUB R3,R1 right after ADD R1,R2
        ins(16'h0000);
        ins(16'h1120);
        ins(16'h2310);
        chk("stall_bubble", 16'(bus.we), 16'h0);
        ins(16'h2310);
        chk("sub_alu", 16'(bus.aluctr), 16'h1);
        chk("sub_rdest", 16'(bus.rdest_r), 16'h3);
        chk("sub_s0", bus.s0, 16'h0011);

        // LDI with gaps before the immediate, then an unused opcode
        ins(16'h8700);
        idle();
        idle();
        chk("imm_wait_we", 16'(bus.we), 16'h0);
        ins(16'hBEEF);
        chk("imm_im16", bus.im16, 16'hBEEF);
        chk("imm_rdest", 16'(bus.rdest_r), 16'h7);
        ins(16'h5123);
        chk("nop_we", 16'(bus.we), 16'h0);

        // reset in the middle of LDI
        ins(16'h8400);
        step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
        ins(16'h1120);
        chk("rmid_we", 16'(bus.we), 16'h1);
        chk("rmid_rdest", 16'(bus.rdest_r), 16'h1);
        chk("rmid_s2ctr", 16'(bus.s2ctr), 16'h0);

        // HALT: stays stopped while write-back still lands
        ins(16'hF000);
        chk("halt_flag", 16'(bus.halted), 16'h1);
        step(1'b0, 1'b1, 16'h1120, 1'b1, 4'h5, 16'h5555);
        for (int k = 0; k < 9; k++) ins(16'h1120);
        chk("halt_ready", 16'(bus.inst_ready), 16'h0);
        chk("halt_rf5", dut.r_rf[5], 16'h5555);
        step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
        chk("halt_cleared", 16'(bus.halted), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
